// File: rtl/hc_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : hc_piso_tx
// Purpose  : Parallel-in / serial-out transmitter. A start request captures
//            an 8-bit parallel word, which is then shifted out one bit per
//            DIV clocks with a bit strobe and busy/done status. Modelled as a
//            17-pin device using library pin numbering.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIV        clocks per serial bit, legal range 1..256
//   MSB_FIRST  1 = D7 transmitted first, 0 = D0 transmitted first
// Ports
//   p1         in   synchronous active-high reset
//   p2         in   clock (rising edge)
//   p3..p10    in   parallel data D0..D7
//   p11        in   DS, serial fill bit entering the vacated tail
//   p12        in   start request
//   p13        out  Q, current serial bit (head of shift register)
//   p14        out  nQ, inverse of Q
//   p15        out  busy, high while a word is being shifted
//   p16        out  done, one-cycle pulse after the last bit period
//   p17        out  bit strobe, first cycle of each bit period
// ============================================================================
module hc_piso_tx #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic p5,
  input  logic p6,
  input  logic p7,
  input  logic p8,
  input  logic p9,
  input  logic p10,
  input  logic p11,
  input  logic p12,
  output logic p13,
  output logic p14,
  output logic p15,
  output logic p16,
  output logic p17
);

  // Terminal value of the per-bit divider. DIV=256 maps onto 8'hFF.
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Pin aliases
  // --------------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic [7:0] d_word;
  logic       ds;
  logic       start;

  assign clk    = p2;
  assign rst    = p1;
  assign d_word = {p10, p9, p8, p7, p6, p5, p4, p3};
  assign ds     = p11;
  assign start  = p12;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     state_q,  state_d;
  logic [7:0] sr_q,     sr_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] divcnt_q, divcnt_d;

  // Decoded helpers
  logic       bit_end;   // last clock of the current bit period
  logic       head_bit;  // bit currently presented on Q
  logic [7:0] sr_shifted;

  assign bit_end = (divcnt_q == DIV_LAST);

  // Shift direction: the head moves away and DS fills the opposite end, so
  // after a full word the register holds the last eight DS samples.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit   = sr_q[7];
      assign sr_shifted = {sr_q[6:0], ds};
    end else begin : g_lsb_first
      assign head_bit   = sr_q[0];
      assign sr_shifted = {ds, sr_q[7:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d     = d_word;
          bitcnt_d = 3'd0;
          divcnt_d = 8'd0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Start is deliberately ignored while a word is in flight.
        if (bit_end) begin
          divcnt_d = 8'd0;
          sr_d     = sr_shifted;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          divcnt_d = divcnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // Accepting start here gives back-to-back words with only the
        // single DONE cycle between them.
        if (start) begin
          sr_d     = d_word;
          bitcnt_d = 3'd0;
          divcnt_d = 8'd0;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_q     <= 8'd0;
      bitcnt_q <= 3'd0;
      divcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign p13 = head_bit;
  assign p14 = ~head_bit;
  assign p15 = (state_q == ST_SHIFT);
  assign p16 = (state_q == ST_DONE);
  assign p17 = (state_q == ST_SHIFT) && (divcnt_q == 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_hc_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc_piso_tx
// Purpose  : Self-checking bench for hc_piso_tx. Four instances with
//            different DIV / bit-order settings share one stimulus stream;
//            each is compared every cycle against a timeline model, plus a
//            vector table and directed sequences on specific instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc_piso_tx;

  localparam int NI = 4;
  localparam int DIVS [NI] = '{1, 4, 2, 3};
  localparam bit MSBS [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d   = 8'h00;
  logic       ds  = 1'b0;
  logic       start = 1'b0;

  logic [NI-1:0] q_w, nq_w, busy_w, done_w, stb_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      hc_piso_tx #(.DIV(DIVS[g]), .MSB_FIRST(MSBS[g])) u_dut (
        .p1 (rst),   .p2 (clk),
        .p3 (d[0]),  .p4 (d[1]), .p5 (d[2]), .p6 (d[3]),
        .p7 (d[4]),  .p8 (d[5]), .p9 (d[6]), .p10(d[7]),
        .p11(ds),    .p12(start),
        .p13(q_w[g]), .p14(nq_w[g]), .p15(busy_w[g]),
        .p16(done_w[g]), .p17(stb_w[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Reference model: a word is a list of bits in transmission order (entry 0
  // is the bit on the line); t is the number of edges since the word's start
  // edge, -1 when idle. All outputs follow from t by the timing rules.
  // --------------------------------------------------------------------------
  logic [7:0] m_list [NI];
  int         m_t    [NI];

  task automatic model_update();
    for (int c = 0; c < NI; c++) begin
      int dv;
      dv = DIVS[c];
      if (rst) begin
        m_t[c]    = -1;
        m_list[c] = 8'h00;
      end else if ((m_t[c] < 0 || m_t[c] == 8 * dv) && start) begin
        m_t[c] = 0;
        for (int i = 0; i < 8; i++)
          m_list[c][i] = MSBS[c] ? d[7 - i] : d[i];
      end else if (m_t[c] >= 0 && m_t[c] < 8 * dv) begin
        if (m_t[c] % dv == dv - 1)
          m_list[c] = {ds, m_list[c][7:1]};  // drop sent bit, DS joins tail
        m_t[c] = m_t[c] + 1;
      end else begin
        m_t[c] = -1;
      end
    end
  endtask

  function automatic logic [4:0] model_out(int c);
    logic b, dn, s, qq;
    b  = (m_t[c] >= 0) && (m_t[c] < 8 * DIVS[c]);
    dn = (m_t[c] == 8 * DIVS[c]);
    s  = b && (m_t[c] % DIVS[c] == 0);
    qq = m_list[c][0];
    return {qq, ~qq, b, dn, s};
  endfunction

  function automatic logic [4:0] dut_out(int c);
    return {q_w[c], nq_w[c], busy_w[c], done_w[c], stb_w[c]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NI; c++)
      check($sformatf("model inst%0d {q,nq,busy,done,stb}", c),
            32'(dut_out(c)), 32'(model_out(c)));
  endtask

  // One clock: inputs already set; model advances on the edge; check after.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // --------------------------------------------------------------------------
  // Vector table for instance 0 (DIV=1, MSB first): reset then word 0xA5.
  // --------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] d;
    logic       ds;
    logic       q, busy, done, stb;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int done_seen;
    logic [7:0] got;
    int nstb;

    for (int c = 0; c < NI; c++) begin
      m_t[c] = -1;
      m_list[c] = 8'h00;
    end

    //            rst   start d      ds    q     busy  done  stb
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; d = vecs[i].d; ds = vecs[i].ds;
      step();
      check($sformatf("vec%0d inst0 {q,nq,busy,done,stb}", i),
            32'(dut_out(0)),
            32'({vecs[i].q, ~vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].stb}));
    end
    idle_steps(40);

    // LSB first, DIV=4, word 0x3C on instance 1: bits sampled at strobes.
    d = 8'h3C; ds = 1'b0; start = 1'b1;
    got = 8'h00; nstb = 0; done_seen = -1;
    for (int s = 0; s < 34; s++) begin
      step();
      start = 1'b0;
      if (stb_w[1]) begin
        if (nstb < 8) got[nstb] = q_w[1];
        nstb++;
      end
      if (done_w[1] && done_seen < 0) done_seen = s;
    end
    check("lsb div4 bits", 32'(got), 32'h3C);
    check("lsb div4 strobes", 32'(nstb), 32'd8);
    check("lsb div4 done edge", 32'(done_seen), 32'd32);
    idle_steps(40);

    // Start held high on instance 2 (DIV=2): 17-cycle word period, mid-word
    // D change only affects the following word.
    d = 8'hF0; start = 1'b1;
    for (int s = 0; s < 35; s++) begin
      step();
      if (s == 4) d = 8'h0F;
      if (s == 1)  check("hold inst2 word1 bit0", 32'(q_w[2]), 32'd1);
      if (s == 9)  check("hold inst2 word1 bit4", 32'(q_w[2]), 32'd0);
      if (s == 16) check("hold inst2 done1", 32'(done_w[2]), 32'd1);
      if (s == 17) check("hold inst2 word2 bit0", 32'(q_w[2]), 32'd0);
      if (s == 25) check("hold inst2 word2 bit4", 32'(q_w[2]), 32'd1);
      if (s == 33) check("hold inst2 done2", 32'(done_w[2]), 32'd1);
    end
    idle_steps(40);

    // Reset during bit 4 of a DIV=3 word on instance 3.
    d = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s < 13; s++) step();   // bit 4 now on the line
    check("abort inst3 busy before", 32'(busy_w[3]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort inst3 {q,busy,done}", 32'({q_w[3], busy_w[3], done_w[3]}), 32'd0);
    done_seen = 0;
    for (int s = 0; s < 30; s++) begin
      step();
      if (done_w[3]) done_seen++;
    end
    check("abort inst3 no done", 32'(done_seen), 32'd0);

    // DS fill on instance 0: zeros go out, DS=1 leaves sr all ones.
    d = 8'h00; ds = 1'b1; start = 1'b1;
    done_seen = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      start = 1'b0;
      if (s < 8 && q_w[0]) done_seen++;
    end
    check("dsfill inst0 word all zero", 32'(done_seen), 32'd0);
    check("dsfill inst0 idle q", 32'({q_w[0], nq_w[0], busy_w[0]}), 32'b100);
    idle_steps(40);

    // Randomized traffic, checked every cycle by the model.
    for (int s = 0; s < 3000; s++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 5) == 0);
      d     = 8'($urandom);
      ds    = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hc_piso_tx.md
Name: hc_piso_tx

Overview:
- Parallel-in/serial-out transmitter: the serializing counterpart to the parallel-capture register parts in the component library.
- On a start request it captures an 8-bit parallel word and shifts it out one bit per DIV clocks, with a bit strobe and busy/done status.
- Modelled as a virtual 17-pin device in library pin naming. It drives serial links into downstream shift-register or latch parts.

Parameters:
- DIV, 1, clocks per serial bit; legal range 1..256.
- MSB_FIRST, 1, 1 = D7 shifted first; 0 = D0 shifted first.

Ports:
- p2  input  1  clock; all state updates on its rising edge.
- p1  input  1  reset; synchronous, active-high.
- p3..p10  input  1 each  parallel data D0..D7 (p3 = D0, p10 = D7).
- p11  input  1  DS, serial fill bit shifted into the vacated tail position.
- p12  input  1  start request, sampled on the clock edge.
- p13  output  1  Q, current serial bit (head of the shift register).
- p14  output  1  nQ, always the inverse of Q.
- p15  output  1  busy, high while a word is being shifted.
- p16  output  1  done, one-cycle pulse after the last bit period.
- p17  output  1  bit strobe, high on the first cycle of each bit period.

Behaviour:
- State: 8-bit shift register `sr`, 3-bit bit counter, 8-bit divider counter, FSM {IDLE, SHIFT, DONE}.
- Reset (p1=1 at an edge): sr=0, counters=0, state=IDLE. Outputs: p13=0, p14=1, p15=0, p16=0, p17=0.
  - Reset overrides start and aborts any word in progress mid-shift; the partial word is discarded and no done pulse is produced.
- Q = sr head: sr[7] if MSB_FIRST, else sr[0]. Q is a combinational function of sr; nQ = ~Q.
- IDLE:
  - p15=0, p16=0, p17=0; Q holds the current head.
  - Start=1 at edge k: sr <= D7..D0, bitcnt <= 0, divcnt <= 0, state <= SHIFT.
- SHIFT:
  - p15=1; p17 = (divcnt == 0).
  - Each edge: divcnt increments. When divcnt == DIV-1, divcnt <= 0 and sr shifts by one toward the head, with DS entering the tail. MSB_FIRST: sr <= {sr[6:0], DS}; else sr <= {DS, sr[7:1]}.
  - At the divcnt == DIV-1 edge:
    - if bitcnt == 7: state <= DONE, with no further shift required to be visible;
    - otherwise: bitcnt increments.
  - Start is ignored in SHIFT.
- DONE (exactly one cycle):
  - p16=1, p15=0, p17=0.
  - Start=1 at this edge is accepted: load, go to SHIFT. This gives back-to-back words with no idle gap beyond the DONE cycle.
  - Otherwise go to IDLE.
- Timing, with start sampled at edge k:
  - p15 rises and Q = first bit after edge k.
  - Bit i (0..7) is valid from edge k+i*DIV to edge k+(i+1)*DIV.
  - p17 pulses after edges k, k+DIV, ..., k+7*DIV.
  - p16=1 and p15=0 after edge k+8*DIV.
  - Total word period is 8*DIV+1 cycles including DONE.
- DIV=1: p17 is high for all 8 SHIFT cycles; a shift occurs every edge.
- DS is sampled at every shift edge, so after a word completes sr holds the last 8 DS samples. The Q value left in IDLE reflects this.
- No X propagation: all registers are initialized by reset; outputs must be defined immediately after the first reset edge.

Test Plan:
- Reset: p1=1 for 2 clocks with p12=1 -> p13=0, p14=1, p15=0, p16=0, p17=0; no load occurs.
- MSB-first word: DIV=1, D=0xA5, DS=0, pulse p12 one cycle -> p13 = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; p15 high 8 cycles; p16 high on cycle 9; p14 always ~p13.
- LSB-first with divider: MSB_FIRST=0, DIV=4, D=0x3C -> p13 = 0,0,1,1,1,1,0,0, each held 4 cycles; p17 high on 1 of every 4 cycles (8 pulses); p16 high after 32 cycles.
- Start handling: D=0xF0, start held high continuously with DIV=2 -> start ignored during SHIFT; reload in the DONE cycle, giving a 17-cycle word period; a mid-word D change to 0x0F does not affect the current word and is sent in the next word.
- Reset mid-word: DIV=3, D=0xFF, assert p1 at bit 4 -> next edge gives p15=0, p13=0, state IDLE; p16 never pulses for the aborted word.
- DS fill: DIV=1, D=0x00, DS=1 through the word -> Q reads 0 for all 8 bits; in the following IDLE p13=1, because sr=0xFF.
